// File: rtl/serdes_pattern_pkg.sv
// serdes_pattern_pkg: shared mode constants and FSM state encoding
package serdes_pattern_pkg;
  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_ONESHOT    = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/pattern_table.sv
// pattern_table: simple dual-port RAM, synchronous read-first, no reset on contents
module pattern_table #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  // same-edge write and read of one address returns the old contents
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/serdes_pattern_sequencer.sv
// serdes_pattern_sequencer: emits pattern table entries at a programmable interval to an OSERDES
module serdes_pattern_sequencer
  import serdes_pattern_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int PERIOD_BITS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [$clog2(DEPTH)-1:0] last_index,
  input  logic [PERIOD_BITS-1:0]   period,
  input  logic                     mode,
  input  logic                     trigger,
  input  logic [WIDTH-1:0]         idle_word,
  output logic [WIDTH-1:0]         word,
  output logic                     sync,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  state_t                 state_q, state_d;
  logic [PERIOD_BITS-1:0] counter_q, counter_d;
  logic [AW-1:0]          index_q, index_d;
  logic                   fire;
  logic                   busy_q, emit1_q, sync1_q, emit2_q, sync2_q, sync_q;
  logic [WIDTH-1:0]       rdata, data2_q, word_q;

  pattern_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clock   (clock),
    .we_i    (write_enable),
    .waddr_i (write_address),
    .wdata_i (write_data),
    .re_i    (fire),
    .raddr_i (index_q),
    .rdata_o (rdata)
  );

  // interval counter and index advance; mode is only consulted in IDLE and at the wrap decision
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    index_d   = index_q;
    fire      = 1'b0;
    if (state_q == ST_IDLE) begin
      counter_d = '0;
      index_d   = '0;
      if (mode == MODE_CONTINUOUS || trigger) state_d = ST_RUN;
    end else if (counter_q == period) begin
      fire      = 1'b1;
      counter_d = '0;
      index_d   = (index_q >= last_index) ? '0 : index_q + AW'(1);
      if (index_q >= last_index && mode == MODE_ONESHOT) state_d = ST_IDLE;
    end else begin
      counter_d = counter_q + PERIOD_BITS'(1);
    end
  end

  // state registers plus the two-stage emit/sync pipeline behind the table read
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      index_q   <= '0;
      busy_q    <= 1'b0;
      emit1_q   <= 1'b0;
      sync1_q   <= 1'b0;
      emit2_q   <= 1'b0;
      sync2_q   <= 1'b0;
      data2_q   <= '0;
      word_q    <= '0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      index_q   <= index_d;
      busy_q    <= (state_q == ST_RUN);
      emit1_q   <= fire;
      sync1_q   <= fire && (index_q == '0);
      emit2_q   <= emit1_q;
      sync2_q   <= sync1_q;
      data2_q   <= rdata;
      word_q    <= emit2_q ? data2_q : idle_word;
      sync_q    <= sync2_q;
    end
  end

  assign word = word_q;
  assign sync = sync_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_serdes_pattern_sequencer.sv
// tb_serdes_pattern_sequencer: directed checks of emission timing, one-shot, collision, reset and boundaries
module tb_serdes_pattern_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [1:0]  write_address = '0;
  logic [7:0]  write_data = '0;
  logic [1:0]  last_index = 2'd3;
  logic [31:0] period = 32'd9;
  logic        mode = 1'b0;
  logic        trigger = 1'b0;
  logic [7:0]  idle_word = 8'h00;
  logic [7:0]  word;
  logic        sync;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  tbl [4] = '{8'hFF, 8'hFE, 8'hC0, 8'h80};

  serdes_pattern_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .last_index    (last_index),
    .period        (period),
    .mode          (mode),
    .trigger       (trigger),
    .idle_word     (idle_word),
    .word          (word),
    .sync          (sync),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    write_enable = 1'b1;
    write_address = a;
    write_data = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_word", word, 8'h00);
    chk("rst_sync", sync, 1'b0);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) wr(2'(i), tbl[i]);
    reset = 1'b0;
    cyc = 0;
    for (int t = 1; t <= 55; t++) begin
      wait_to(t);
      chk("cont_word", word, (t >= 13 && (t - 13) % 10 == 0) ? tbl[((t - 13) / 10) % 4] : 8'h00);
      chk("cont_sync", sync, (t >= 13 && (t - 13) % 40 == 0) ? 1'b1 : 1'b0);
      chk("cont_busy", busy, (t >= 2) ? 1'b1 : 1'b0);
    end

    mode = 1'b1;
    period = 32'd2;
    restart();
    tick();
    chk("os_idle_busy", busy, 1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    cyc = 0;
    chk("os_t0_busy", busy, 1'b0);
    for (int t = 1; t <= 25; t++) begin
      tick();
      chk("os_word", word, (t >= 5 && t <= 14 && (t - 5) % 3 == 0) ? tbl[(t - 5) / 3] : 8'h00);
      chk("os_sync", sync, (t == 5) ? 1'b1 : 1'b0);
      chk("os_busy", busy, (t >= 1 && t <= 12) ? 1'b1 : 1'b0);
      trigger = (t == 3);
    end
    trigger = 1'b0;

    mode = 1'b0;
    period = 32'd0;
    last_index = 2'd1;
    reset = 1'b1;
    wr(2'd0, 8'hAA);
    wr(2'd1, 8'h55);
    restart();
    for (int t = 1; t <= 13; t++) begin
      wait_to(t);
      chk("b2b_word", word, (t < 4) ? 8'h00 : ((t % 2 == 0) ? 8'hAA : 8'h55));
      chk("b2b_sync", sync, (t >= 4 && t % 2 == 0) ? 1'b1 : 1'b0);
    end

    period = 32'd9;
    last_index = 2'd3;
    reset = 1'b1;
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hFE);
    restart();
    wait_to(30);
    write_enable = 1'b1;
    write_address = 2'd2;
    write_data = 8'h3C;
    wait_to(31);
    write_enable = 1'b0;
    wait_to(33);
    chk("coll_old", word, 8'hC0);
    wait_to(43);
    chk("coll_e3", word, 8'h80);
    wait_to(53);
    chk("coll_wrap", word, 8'hFF);
    chk("coll_wrap_sync", sync, 1'b1);
    wait_to(73);
    chk("coll_new", word, 8'h3C);

    idle_word = 8'h5A;
    restart();
    wait_to(23);
    chk("mid_e2", word, 8'hFE);
    wait_to(25);
    chk("mid_idle", word, 8'h5A);
    reset = 1'b1;
    tick();
    chk("mid_rst_word", word, 8'h00);
    chk("mid_rst_sync", sync, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    cyc = 0;
    wait_to(12);
    chk("rel_idle", word, 8'h5A);
    wait_to(13);
    chk("rel_e0", word, 8'hFF);
    chk("rel_e0_sync", sync, 1'b1);
    wait_to(23);
    chk("rel_e1", word, 8'hFE);

    idle_word = 8'h00;
    restart();
    wait_to(25);
    last_index = 2'd1;
    wait_to(33);
    chk("bnd_e2", word, 8'h3C);
    chk("bnd_e2_sync", sync, 1'b0);
    wait_to(35);
    chk("idle_old", word, 8'h00);
    idle_word = 8'h77;
    wait_to(36);
    chk("idle_new", word, 8'h77);
    wait_to(43);
    chk("bnd_wrap", word, 8'hFF);
    chk("bnd_wrap_sync", sync, 1'b1);
    wait_to(53);
    chk("bnd_e1", word, 8'hFE);
    wait_to(63);
    chk("bnd_e0_again", word, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serdes_pattern_sequencer.md
# serdes_pattern_sequencer

Parametrised pattern-word generator feeding an 8:1 (or other width) OSERDES pair on the word clock. It emits entries from a small writable pattern table at a programmable interval and drives a configurable idle word between emissions. It supports continuous and triggered one-shot sequences, with a sync pulse marking table entry 0. It sits between control logic (register file or test top) and the serializer/PLL wrapper, in the `clock` domain.

## Interface
- `WIDTH`, 8: serializer word width in bits; MSB is serialized first.
- `DEPTH`, 4: pattern table entries; power of 2, ≥ 2.
- `PERIOD_BITS`, 32: width of the interval counter.
- `clock`  in  1: word clock, same as OSERDES CLKDIV. One clock domain.
- `reset`  in  1: synchronous, active-high.
- `write_enable`  in  1: table write strobe.
- `write_address`  in  $clog2(DEPTH): table write index.
- `write_data`  in  WIDTH: table write data.
- `last_index`  in  $clog2(DEPTH): index of the final entry in the sequence.
- `period`  in  PERIOD_BITS: emissions occur every `period`+1 clocks.
- `mode`  in  1: 0 = continuous, 1 = one-shot.
- `trigger`  in  1: starts one sequence when in one-shot mode and IDLE.
- `idle_word`  in  WIDTH: word output when no entry is being emitted.
- `word`  out  WIDTH: registered word to the serializer.
- `sync`  out  1: one-cycle pulse coincident with entry 0 on `word`.
- `busy`  out  1: high while in RUN.

## Operation
- Table: DEPTH×WIDTH, one write port and one synchronous read port, read-first. Contents are not cleared by reset. A write takes effect on the next clock.
- States: IDLE, RUN.
  - IDLE: `index`=0, `counter`=0. Enter RUN when `mode`==0, or when `mode`==1 and `trigger`==1.
  - RUN: `counter` increments each clock. When `counter`==`period`, `counter`←0, entry `index` is emitted, and the index advances.
  - Advance rule: if `index` ≥ `last_index` (compared live), then:
    - `mode`==0: `index`←0, stay in RUN.
    - `mode`==1: return to IDLE.
  - Otherwise `index`←`index`+1.
- `mode` is sampled only in IDLE and at the wrap/end decision. A mode change mid-sequence takes effect at the end of that sequence.
- `trigger` is ignored in RUN and in continuous mode.
- `period`=0: one entry is emitted every clock, and `word` never shows `idle_word` while RUN.
- `last_index`=0: entry 0 is repeated, and `sync` pulses on every emission.
- Lowering `last_index` below the current `index` ends the sequence at the next emission.
- Reset mid-sequence: immediate return to IDLE. Pending emissions are dropped and the table is unchanged.

## Timing
- Reset values: `word`=0, `sync`=0, `busy`=0.
- Latency: the emission decision is made on the edge where `counter`==`period`. The table read is issued on that edge, and `word` shows the entry 2 clocks later for exactly one clock. `sync` is aligned with `word`.
- `busy` rises the clock after the IDLE→RUN transition edge. It falls the clock after the last emission decision. The final `word` may still appear 1 clock after `busy` falls.
- Continuous mode from reset release: the first emission decision comes after `period`+1 RUN clocks.
- Simultaneous write and emission read of the same address: the old contents are emitted.
- Outside emission cycles, `word`=`idle_word`, registered: a change on `idle_word` appears 1 clock later.

## Structure
- Shared package `serdes_pattern_pkg`:
  - `MODE_CONTINUOUS`=0, `MODE_ONESHOT`=1.
  - State encodings IDLE/RUN.
- Sub-module `pattern_table`: parametrised simple dual-port RAM with synchronous read-first behaviour, BRAM/distributed inferable.
- The top holds the FSM, `counter`, `index`, and the 2-stage emit/sync pipeline.

## Test plan
- Continuous basic: WIDTH=8, DEPTH=4, table {FF,FE,C0,80}, `last_index`=3, `period`=9, `idle_word`=00, `mode`=0 → `word` shows FF,FE,C0,80 repeating, each one clock, 10 clocks apart, 00 otherwise. `sync` pulses only with FF.
- One-shot: `mode`=1, `trigger` pulse → exactly 4 emissions, then `busy`=0 and `word`=00. A second `trigger` during RUN produces no extra emissions.
- Back-to-back: `period`=0, `last_index`=1, table {AA,55} → `word` alternates AA,55 every clock with no idle gaps. `sync` fires every 2 clocks.
- Collision: write 3C to address 2 on the same edge that entry 2 is read → old value C0 is emitted, and 3C appears on the next pass.
- Reset mid-run: assert `reset` between emissions 2 and 3 → the next clock gives `word`=0, `sync`=0, `busy`=0. After release, the sequence restarts at entry 0 with table contents intact.
- Boundary: `last_index` lowered from 3 to 1 while `index`=2 → the next emission is entry 2, followed by a wrap to entry 0.
